// File: rtl/vx_task_dispatch.sv
// vx_task_dispatch: collects task packets from NUM_INPUTS producers into a
// shared FIFO and hands each one to exactly one of NUM_OUTPUTS clusters.
// Each cluster has a credit counter of outstanding tasks. A credit is reserved
// when a task is loaded into the output stage and returned by a done pulse.
//
// Handshake semantics (input and output sides alike): a transfer happens on a
// rising clk edge where valid and ready are both 1. Once out_valid is raised,
// out_valid and out_data stay stable until the transfer happens. in_ready is
// computed from the current in_valid pattern and the FIFO fill level.
module vx_task_dispatch #(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_CREDITS = 2,
    parameter int POLICY      = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_INPUTS-1:0]              in_ready,
    output logic [NUM_OUTPUTS-1:0]             out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    input  logic [NUM_OUTPUTS-1:0]             out_ready,
    input  logic [NUM_OUTPUTS-1:0]             done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending,
    output logic                               busy
);

    localparam int PW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_CREDITS + 1);
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int OW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    // Input arbitration
    logic [IW-1:0]         in_ptr_q, in_ptr_d;
    logic [IW-1:0]         grant_idx;
    logic                  grant_any;
    logic                  push;

    // Shared FIFO
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  fifo_full, fifo_empty;
    logic                  pop;

    // Output stage and credits
    logic [NUM_OUTPUTS-1:0] out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [OW-1:0]          out_ptr_q, out_ptr_d;
    logic [CW-1:0]          credit_q [NUM_OUTPUTS];
    logic [CW-1:0]          credit_d [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] eligible;
    logic [NUM_OUTPUTS-1:0] cr_inc, cr_dec;
    logic [OW-1:0]          sel_idx;
    logic                   sel_any;
    logic [CW-1:0]          best_cr;
    logic                   fire, load, any_credit;
    logic                   busy_q, busy_d;

    assign fifo_full  = (count_q == PW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fire       = |(out_valid_q & out_ready);

    // Round-robin grant over in_valid, searching from in_ptr_q upward.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!grant_any && in_valid[(int'(in_ptr_q) + k) % NUM_INPUTS]) begin
                grant_any = 1'b1;
                grant_idx = IW'((int'(in_ptr_q) + k) % NUM_INPUTS);
            end
        end
    end

    // Accept only the granted producer, never while full or in reset; the
    // pointer moves past the winner only when a push really happens.
    always_comb begin
        in_ready = '0;
        push     = 1'b0;
        in_ptr_d = in_ptr_q;
        if (!reset && !fifo_full && grant_any) begin
            in_ready[grant_idx] = 1'b1;
            push                = 1'b1;
            in_ptr_d            = IW'((int'(grant_idx) + 1) % NUM_INPUTS);
        end
    end

    // A cluster may take another task while its registered count is below the limit.
    always_comb begin
        eligible = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            eligible[j] = (credit_q[j] < CW'(MAX_CREDITS));
        end
    end

    // Destination choice: rotating search or minimum credit (lowest index wins ties).
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        best_cr = '0;
        if (POLICY == 0) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (!sel_any && eligible[(int'(out_ptr_q) + k) % NUM_OUTPUTS]) begin
                    sel_any = 1'b1;
                    sel_idx = OW'((int'(out_ptr_q) + k) % NUM_OUTPUTS);
                end
            end
        end else begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (eligible[j] && (!sel_any || (credit_q[j] < best_cr))) begin
                    sel_any = 1'b1;
                    sel_idx = OW'(j);
                    best_cr = credit_q[j];
                end
            end
        end
    end

    assign load = enable && !fifo_empty && sel_any && ((out_valid_q == '0) || fire);
    assign pop  = load;

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PW'(1);
        end
    end

    // Output register: load a new task or drop the offer once it has fired.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ptr_d   = out_ptr_q;
        if (load) begin
            out_valid_d          = '0;
            out_valid_d[sel_idx] = 1'b1;
            out_data_d           = fifo_mem_q[rd_ptr_q];
            out_ptr_d            = OW'((int'(sel_idx) + 1) % NUM_OUTPUTS);
        end else if (fire) begin
            out_valid_d = '0;
        end
    end

    // Credit update: reserve on load, return on done; both together cancel out.
    always_comb begin
        cr_inc     = '0;
        cr_dec     = '0;
        any_credit = 1'b0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            credit_d[j] = credit_q[j];
            cr_inc[j]   = load && (sel_idx == OW'(j));
            cr_dec[j]   = done[j] && (credit_q[j] != '0);
            if (cr_inc[j] && !cr_dec[j]) begin
                credit_d[j] = credit_q[j] + CW'(1);
            end else if (cr_dec[j] && !cr_inc[j]) begin
                credit_d[j] = credit_q[j] - CW'(1);
            end
            any_credit = any_credit | (credit_q[j] != '0);
        end
        busy_d = !fifo_empty || (|out_valid_q) || any_credit;
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // State registers; reset discards queued/offered work and all credits.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_ptr_q   <= '0;
            busy_q      <= 1'b0;
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                credit_q[j] <= '0;
            end
        end else begin
            in_ptr_q    <= in_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ptr_q   <= out_ptr_d;
            busy_q      <= busy_d;
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                credit_q[j] <= credit_d[j];
            end
        end
    end

    // Flag a completion from a cluster that had nothing outstanding.
    always @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                assert (!(done[j] && (credit_q[j] == '0)))
                    else $warning("done on output %0d with zero credit, ignored", j);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pending   = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vx_task_dispatch.sv
// Bench for vx_task_dispatch. Instance a: round-robin, two producers.
// Instance b: least-loaded, one producer. Both use 4 outputs, 16-bit packets,
// a 4-entry FIFO and 2 credits per output.
module tb_vx_task_dispatch;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_enable;
    logic [1:0]  a_in_valid;
    logic [31:0] a_in_data;
    logic [1:0]  a_in_ready;
    logic [3:0]  a_out_valid;
    logic [15:0] a_out_data;
    logic [3:0]  a_out_ready;
    logic [3:0]  a_done;
    logic [2:0]  a_pending;
    logic        a_busy;

    logic        b_enable;
    logic [0:0]  b_in_valid;
    logic [15:0] b_in_data;
    logic [0:0]  b_in_ready;
    logic [3:0]  b_out_valid;
    logic [15:0] b_out_data;
    logic [3:0]  b_out_ready;
    logic [3:0]  b_done;
    logic [2:0]  b_pending;
    logic        b_busy;

    int cmp_count  = 0;
    int fail_count = 0;

    typedef struct {
        logic        en;
        logic [1:0]  iv;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [3:0]  ordy;
        logic [3:0]  dn;
        logic [1:0]  ir;
        logic [3:0]  ov;
        logic [15:0] od;
        logic [2:0]  pend;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    vx_task_dispatch #(.NUM_INPUTS(2), .NUM_OUTPUTS(4), .DATA_WIDTH(16), .FIFO_DEPTH(4),
                       .MAX_CREDITS(2), .POLICY(0)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .done(a_done), .pending(a_pending), .busy(a_busy)
    );

    vx_task_dispatch #(.NUM_INPUTS(1), .NUM_OUTPUTS(4), .DATA_WIDTH(16), .FIFO_DEPTH(4),
                       .MAX_CREDITS(2), .POLICY(1)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .done(b_done), .pending(b_pending), .busy(b_busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic void add_vec(input logic en, input logic [1:0] iv,
                                    input logic [15:0] d0, input logic [15:0] d1,
                                    input logic [3:0] ordy, input logic [3:0] dn,
                                    input logic [1:0] ir, input logic [3:0] ov,
                                    input logic [15:0] od, input logic [2:0] pend,
                                    input logic bsy);
        vec_t v;
        v.en = en; v.iv = iv; v.d0 = d0; v.d1 = d1; v.ordy = ordy; v.dn = dn;
        v.ir = ir; v.ov = ov; v.od = od; v.pend = pend; v.bsy = bsy;
        tbl.push_back(v);
    endfunction

    task automatic idle_inputs();
        a_enable = 1'b1; a_in_valid = '0; a_in_data = '0; a_out_ready = '0; a_done = '0;
        b_enable = 1'b1; b_in_valid = '0; b_in_data = '0; b_out_ready = '0; b_done = '0;
    endtask

    // Reset both instances; returns 1 time unit after the last reset edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Apply tbl one row per cycle to instance a (use_b=0) or b (use_b=1).
    task automatic run_table(input bit use_b, input string tag);
        logic [1:0]  act_ir;
        logic [3:0]  act_ov;
        logic [15:0] act_od;
        logic [2:0]  act_pend;
        logic        act_bsy;
        for (int i = 0; i < tbl.size(); i++) begin
            if (!use_b) begin
                a_enable = tbl[i].en; a_in_valid = tbl[i].iv;
                a_in_data = {tbl[i].d1, tbl[i].d0};
                a_out_ready = tbl[i].ordy; a_done = tbl[i].dn;
            end else begin
                b_enable = tbl[i].en; b_in_valid = tbl[i].iv[0]; b_in_data = tbl[i].d0;
                b_out_ready = tbl[i].ordy; b_done = tbl[i].dn;
            end
            @(negedge clk);
            if (!use_b) begin
                act_ir = a_in_ready; act_ov = a_out_valid; act_od = a_out_data;
                act_pend = a_pending; act_bsy = a_busy;
            end else begin
                act_ir = {1'b0, b_in_ready}; act_ov = b_out_valid; act_od = b_out_data;
                act_pend = b_pending; act_bsy = b_busy;
            end
            check({tag, ".in_ready"}, i, 32'(act_ir), 32'(tbl[i].ir));
            check({tag, ".out_valid"}, i, 32'(act_ov), 32'(tbl[i].ov));
            if (tbl[i].ov != 4'b0000) check({tag, ".out_data"}, i, 32'(act_od), 32'(tbl[i].od));
            check({tag, ".pending"}, i, 32'(act_pend), 32'(tbl[i].pend));
            check({tag, ".busy"}, i, 32'(act_bsy), 32'(tbl[i].bsy));
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();

        // ---- reset state, in_ready low during reset ----
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_in_valid = 2'b11; b_in_valid = 1'b1;
        @(negedge clk);
        check("rst.a_in_ready", 0, 32'(a_in_ready), 32'h0);
        check("rst.b_in_ready", 0, 32'(b_in_ready), 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        check("rst.a_out_valid", 0, 32'(a_out_valid), 32'h0);
        check("rst.a_out_data", 0, 32'(a_out_data), 32'h0);
        check("rst.a_pending", 0, 32'(a_pending), 32'h0);
        check("rst.a_busy", 0, 32'(a_busy), 32'h0);
        check("rst.b_out_valid", 0, 32'(b_out_valid), 32'h0);
        check("rst.b_pending", 0, 32'(b_pending), 32'h0);
        check("rst.b_busy", 0, 32'(b_busy), 32'h0);

        // ---- round-robin credit limit, then done[2] releases task 9 ----
        do_reset();
        tbl.delete();
        //      en iv     d0     d1 ordy  done     ir     ov       od pend busy
        add_vec(1, 2'b01, 16'd1, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 0, 0);
        add_vec(1, 2'b01, 16'd2, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 1, 0);
        add_vec(1, 2'b01, 16'd3, 0, 4'hF, 4'h0, 2'b01, 4'b0001, 1, 1, 1);
        add_vec(1, 2'b01, 16'd4, 0, 4'hF, 4'h0, 2'b01, 4'b0010, 2, 1, 1);
        add_vec(1, 2'b01, 16'd5, 0, 4'hF, 4'h0, 2'b01, 4'b0100, 3, 1, 1);
        add_vec(1, 2'b01, 16'd6, 0, 4'hF, 4'h0, 2'b01, 4'b1000, 4, 1, 1);
        add_vec(1, 2'b01, 16'd7, 0, 4'hF, 4'h0, 2'b01, 4'b0001, 5, 1, 1);
        add_vec(1, 2'b01, 16'd8, 0, 4'hF, 4'h0, 2'b01, 4'b0010, 6, 1, 1);
        add_vec(1, 2'b01, 16'd9, 0, 4'hF, 4'h0, 2'b01, 4'b0100, 7, 1, 1);
        add_vec(1, 2'b00, 16'd0, 0, 4'hF, 4'h0, 2'b00, 4'b1000, 8, 1, 1);
        add_vec(1, 2'b00, 16'd0, 0, 4'hF, 4'h4, 2'b00, 4'b0000, 0, 1, 1);
        add_vec(1, 2'b00, 16'd0, 0, 4'hF, 4'h0, 2'b00, 4'b0000, 0, 1, 1);
        add_vec(1, 2'b00, 16'd0, 0, 4'hF, 4'h0, 2'b00, 4'b0100, 9, 0, 1);
        run_table(1'b0, "rr");

        // ---- backpressure on output 0, FIFO fills, then drains one per cycle ----
        do_reset();
        tbl.delete();
        add_vec(1, 2'b01, 16'hAB, 0, 4'hE, 4'h0, 2'b01, 4'b0000, 0, 0, 0);
        add_vec(1, 2'b01, 16'h01, 0, 4'hE, 4'h0, 2'b01, 4'b0000, 0, 1, 0);
        add_vec(1, 2'b01, 16'h02, 0, 4'hE, 4'h0, 2'b01, 4'b0001, 16'hAB, 1, 1);
        add_vec(0, 2'b01, 16'h03, 0, 4'hE, 4'h0, 2'b01, 4'b0001, 16'hAB, 2, 1);
        add_vec(0, 2'b01, 16'h04, 0, 4'hE, 4'h0, 2'b01, 4'b0001, 16'hAB, 3, 1);
        add_vec(1, 2'b01, 16'h05, 0, 4'hE, 4'h0, 2'b00, 4'b0001, 16'hAB, 4, 1);
        add_vec(1, 2'b01, 16'h05, 0, 4'hE, 4'h0, 2'b00, 4'b0001, 16'hAB, 4, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0001, 16'hAB, 4, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0010, 16'h01, 3, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0100, 16'h02, 2, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b1000, 16'h03, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0001, 16'h04, 0, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0000, 0, 0, 1);
        run_table(1'b0, "bp");

        // ---- input fairness with both producers valid, outputs stalled ----
        do_reset();
        tbl.delete();
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b01, 4'b0000, 0, 0, 0);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b10, 4'b0000, 0, 1, 0);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b01, 4'b0001, 16'h0A0, 1, 1);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b10, 4'b0001, 16'h0A0, 2, 1);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b01, 4'b0001, 16'h0A0, 3, 1);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b00, 4'b0001, 16'h0A0, 4, 1);
        add_vec(1, 2'b11, 16'h0A0, 16'h0B0, 4'h0, 4'h0, 2'b00, 4'b0001, 16'h0A0, 4, 1);
        run_table(1'b0, "fair");

        // ---- load to output 1 in the same cycle as done[1] ----
        do_reset();
        tbl.delete();
        add_vec(1, 2'b01, 16'h11, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 0, 0);
        add_vec(1, 2'b01, 16'h12, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 1, 0);
        add_vec(1, 2'b01, 16'h13, 0, 4'hF, 4'h0, 2'b01, 4'b0001, 16'h11, 1, 1);
        add_vec(1, 2'b01, 16'h14, 0, 4'hF, 4'h0, 2'b01, 4'b0010, 16'h12, 1, 1);
        add_vec(1, 2'b01, 16'h15, 0, 4'hF, 4'h0, 2'b01, 4'b0100, 16'h13, 1, 1);
        add_vec(1, 2'b01, 16'h16, 0, 4'hF, 4'h0, 2'b01, 4'b1000, 16'h14, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h2, 2'b00, 4'b0001, 16'h15, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0010, 16'h16, 0, 1);
        run_table(1'b0, "simul");
        @(negedge clk);
        check("simul.credit0", 0, 32'(dut_a.credit_q[0]), 32'd2);
        check("simul.credit1", 0, 32'(dut_a.credit_q[1]), 32'd1);
        check("simul.credit2", 0, 32'(dut_a.credit_q[2]), 32'd1);
        check("simul.credit3", 0, 32'(dut_a.credit_q[3]), 32'd1);
        @(posedge clk);
        #1;

        // ---- reset with 3 tasks queued and 1 offered; done during reset ----
        do_reset();
        a_out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 2'b01;
            a_in_data  = {16'h0, 16'(16'h40 + k)};
            @(posedge clk);
            #1;
        end
        a_in_valid = 2'b00;
        @(negedge clk);
        check("midrst.pre_pending", 0, 32'(a_pending), 32'd3);
        check("midrst.pre_out_valid", 0, 32'(a_out_valid), 32'b0001);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_done = 4'hF;
        a_in_valid = 2'b01;
        @(negedge clk);
        check("midrst.in_ready", 0, 32'(a_in_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_done = 4'h0;
        a_in_valid = 2'b00;
        @(negedge clk);
        check("midrst.pending", 0, 32'(a_pending), 32'd0);
        check("midrst.out_valid", 0, 32'(a_out_valid), 32'h0);
        check("midrst.busy", 0, 32'(a_busy), 32'h0);
        for (int j = 0; j < 4; j++) begin
            check("midrst.credit", j, 32'(dut_a.credit_q[j]), 32'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst.busy_after", 0, 32'(a_busy), 32'h0);
        @(posedge clk);
        #1;

        // ---- least-loaded: preload {2,1,0,1}, then three tasks ----
        do_reset();
        tbl.delete();
        add_vec(1, 2'b01, 16'h21, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 0, 0);
        add_vec(1, 2'b01, 16'h22, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 1, 0);
        add_vec(1, 2'b01, 16'h23, 0, 4'hF, 4'h0, 2'b01, 4'b0001, 16'h21, 1, 1);
        add_vec(1, 2'b01, 16'h24, 0, 4'hF, 4'h0, 2'b01, 4'b0010, 16'h22, 1, 1);
        add_vec(1, 2'b01, 16'h25, 0, 4'hF, 4'h0, 2'b01, 4'b0100, 16'h23, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b1000, 16'h24, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h4, 2'b00, 4'b0001, 16'h25, 0, 1);
        add_vec(1, 2'b01, 16'h31, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 0, 1);
        add_vec(1, 2'b01, 16'h32, 0, 4'hF, 4'h0, 2'b01, 4'b0000, 0, 1, 1);
        add_vec(1, 2'b01, 16'h33, 0, 4'hF, 4'h0, 2'b01, 4'b0100, 16'h31, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0010, 16'h32, 1, 1);
        add_vec(1, 2'b00, 16'h00, 0, 4'hF, 4'h0, 2'b00, 4'b0100, 16'h33, 0, 1);
        run_table(1'b1, "ll");

        // ---- done on a zero-credit output: counter stays at 0 ----
        do_reset();
        b_done = 4'b1000;
        @(posedge clk);
        #1;
        b_done = 4'b0000;
        @(negedge clk);
        check("zero_done.credit3", 0, 32'(dut_b.credit_q[3]), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("zero_done.busy", 0, 32'(b_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
